// File: rtl/hamming_codec_seq.sv
// Burst test sequencer for the 16->21 bit Hamming codec pair: drives LFSR words,
// injects codeword bit flips aligned to the coder register, and scores the decoded output.
module hamming_codec_seq #(
    parameter int unsigned LAT      = 2,
    parameter logic [15:0] DEF_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [4:0]  flip_pos,
    input  logic [15:0] num_words,
    input  logic [15:0] seed,
    output logic [15:0] codec_data_in,
    output logic [20:0] codec_bit_flip,
    input  logic [15:0] codec_data_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic        first_err_valid
);

    localparam int unsigned        DRAIN_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT - 1);
    localparam logic [4:0]         LAST_POS   = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        M_NONE   = 2'd0,
        M_SINGLE = 2'd1,
        M_WALK   = 2'd2,
        M_DOUBLE = 2'd3
    } flip_mode_e;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p >= LAST_POS) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e              state_q, state_d;
    flip_mode_e          mode_q, mode_d;
    logic [4:0]          pos_q, pos_d;
    logic [4:0]          walk_q, walk_d;
    logic [15:0]         num_q, num_d;
    logic [15:0]         issued_q, issued_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [20:0]         flip_q, flip_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [15:0]         first_idx_q, first_idx_d;
    logic                first_vld_q, first_vld_d;
    logic [15:0]         sent_pipe_q [LAT];
    logic [LAT-1:0]      valid_pipe_q;

    logic        accept;
    logic        load;
    logic [4:0]  pos_clean;
    logic [15:0] seed_eff;
    logic        check_vld;
    logic        mismatch;

    assign accept    = (state_q == S_IDLE) && start;
    assign load      = accept && (num_words != 16'd0);
    assign pos_clean = (flip_pos > LAST_POS) ? 5'd0 : flip_pos;
    assign seed_eff  = (seed == 16'd0) ? DEF_SEED : seed;
    assign check_vld = valid_pipe_q[LAT-1];
    assign mismatch  = codec_data_out != sent_pipe_q[LAT-1];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_words == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_q == num_q - 16'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy          = state_q != S_IDLE;
        done          = state_q == S_DONE;
        codec_data_in = (state_q == S_RUN) ? lfsr_q : 16'd0;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        mode_d      = mode_q;
        pos_d       = pos_q;
        walk_d      = walk_q;
        num_d       = num_q;
        issued_d    = issued_q;
        lfsr_d      = lfsr_q;
        drain_d     = '0;
        flip_d      = '0;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;

        if (state_q == S_RUN) begin
            lfsr_d   = lfsr_step(lfsr_q);
            issued_d = issued_q + 16'd1;
            walk_d   = wrap_inc(walk_q);
            unique case (mode_q)
                M_NONE:   flip_d = '0;
                M_SINGLE: flip_d = 21'd1 << pos_q;
                M_WALK:   flip_d = 21'd1 << walk_q;
                M_DOUBLE: flip_d = (21'd1 << pos_q) | (21'd1 << wrap_inc(pos_q));
                default:  flip_d = '0;
            endcase
        end

        if (state_q == S_DRAIN) begin
            drain_d = drain_q + DRAIN_W'(1);
        end

        // The word index of the checked word equals the count before this increment.
        if (check_vld) begin
            word_cnt_d = sat_inc(word_cnt_q);
            if (mismatch) begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (!first_vld_q) begin
                    first_idx_d = word_cnt_q;
                    first_vld_d = 1'b1;
                end
            end
        end

        if (load) begin
            mode_d      = flip_mode_e'(mode);
            pos_d       = pos_clean;
            walk_d      = pos_clean;
            num_d       = num_words;
            issued_d    = '0;
            lfsr_d      = seed_eff;
            word_cnt_d  = '0;
            err_cnt_d   = '0;
            first_idx_d = '0;
            first_vld_d = 1'b0;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= M_NONE;
            pos_q        <= '0;
            walk_q       <= '0;
            num_q        <= '0;
            issued_q     <= '0;
            lfsr_q       <= DEF_SEED;
            drain_q      <= '0;
            flip_q       <= '0;
            word_cnt_q   <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_vld_q  <= 1'b0;
            valid_pipe_q <= '0;
        end else begin
            mode_q       <= mode_d;
            pos_q        <= pos_d;
            walk_q       <= walk_d;
            num_q        <= num_d;
            issued_q     <= issued_d;
            lfsr_q       <= lfsr_d;
            drain_q      <= drain_d;
            flip_q       <= flip_d;
            word_cnt_q   <= word_cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_vld_q  <= first_vld_d;
            valid_pipe_q[0] <= state_q == S_RUN;
            for (int i = 1; i < LAT; i++) begin
                valid_pipe_q[i] <= valid_pipe_q[i-1];
            end
        end
    end

    // NOTE: the sent-word delay line is left unreset; the reset valid pipe qualifies every use.
    always_ff @(posedge clk) begin
        sent_pipe_q[0] <= codec_data_in;
        for (int i = 1; i < LAT; i++) begin
            sent_pipe_q[i] <= sent_pipe_q[i-1];
        end
    end

    assign codec_bit_flip  = flip_q;
    assign word_count      = word_cnt_q;
    assign err_count       = err_cnt_q;
    assign first_err_idx   = first_idx_q;
    assign first_err_valid = first_vld_q;

endmodule

// File: tb/tb_hamming_codec_seq.sv
// Self-checking bench: behavioural Hamming codec with LAT=2 around the sequencer,
// scoreboard queues of expected words/flip masks filled when each burst is launched.
module tb_hamming_codec_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  flip_pos;
    logic [15:0] num_words;
    logic [15:0] seed;
    logic [15:0] codec_data_in;
    logic [20:0] codec_bit_flip;
    logic [15:0] codec_data_out;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic        first_err_valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_word_q [$];
    logic [20:0] exp_mask_q [$];

    hamming_codec_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .flip_pos        (flip_pos),
        .num_words       (num_words),
        .seed            (seed),
        .codec_data_in   (codec_data_in),
        .codec_bit_flip  (codec_bit_flip),
        .codec_data_out  (codec_data_out),
        .busy            (busy),
        .done            (done),
        .word_count      (word_count),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hamming(21,16): parity at 1-based positions 1,2,4,8,16; data fills the rest in order.
    function automatic logic [20:0] ham_enc(input logic [15:0] d);
        logic [20:0] c;
        logic        par;
        int          j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 21; pos++) begin
                if ((pos & (1 << k)) != 0) par ^= c[pos-1];
            end
            c[(1 << k) - 1] = par;
        end
        return c;
    endfunction

    function automatic logic [15:0] ham_dec(input logic [20:0] cw);
        logic [20:0] c;
        logic [15:0] d;
        int          syn;
        int          j;
        c   = cw;
        syn = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if (c[pos-1]) syn ^= pos;
        end
        if (syn >= 1 && syn <= 21) c[syn-1] = ~c[syn-1];
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    // Codec model: coder register, flip applied to the registered codeword, decoder register.
    logic [20:0] coded_q;
    logic [15:0] decoded_q;
    always_ff @(posedge clk) begin
        coded_q   <= ham_enc(codec_data_in);
        decoded_q <= ham_dec(coded_q ^ codec_bit_flip);
    end
    assign codec_data_out = decoded_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_burst(input string tag, input logic [1:0] m, input logic [4:0] p,
                             input logic [15:0] n, input logic [15:0] s, input bit poke_drain);
        logic [15:0] lf;
        logic [4:0]  pe;
        logic [4:0]  walk;
        logic [20:0] msk;
        logic [15:0] w;
        int          exp_err;
        int          exp_first;
        int          done_k;
        int          done_n;
        int          busy_bad;
        int          stray;
        int          last_k;

        lf        = (s == 16'd0) ? 16'hACE1 : s;
        pe        = (p > 5'd20) ? 5'd0 : p;
        walk      = pe;
        exp_err   = 0;
        exp_first = -1;
        for (int i = 0; i < int'(n); i++) begin
            case (m)
                2'd1:    msk = 21'd1 << pe;
                2'd2: begin
                    msk  = 21'd1 << walk;
                    walk = (walk == 5'd20) ? 5'd0 : walk + 5'd1;
                end
                2'd3:    msk = (21'd1 << pe) | (21'd1 << ((pe == 5'd20) ? 5'd0 : pe + 5'd1));
                default: msk = '0;
            endcase
            exp_word_q.push_back(lf);
            exp_mask_q.push_back(msk);
            if (ham_dec(ham_enc(lf) ^ msk) != lf) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end

        mode      = m;
        flip_pos  = p;
        num_words = n;
        seed      = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;

        done_k   = 0;
        done_n   = 0;
        busy_bad = 0;
        stray    = 0;
        last_k   = int'(n) + 6;
        for (int k = 1; k <= last_k; k++) begin
            if (k <= int'(n) && exp_word_q.size() > 0) begin
                w = exp_word_q.pop_front();
                check({tag, "_word"}, 32'(codec_data_in), 32'(w));
            end else if (codec_data_in != 16'd0) begin
                stray++;
            end
            if (k >= 2 && k <= int'(n) + 1 && exp_mask_q.size() > 0) begin
                msk = exp_mask_q.pop_front();
                check({tag, "_flip"}, 32'(codec_bit_flip), 32'(msk));
            end else if (codec_bit_flip != 21'd0) begin
                stray++;
            end
            if (busy != (k <= int'(n) + 3)) busy_bad++;
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (poke_drain && k == int'(n) + 1) begin
                num_words = 16'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;

        check({tag, "_done_cycle"}, done_k, int'(n) + 3);
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_busy_window"}, busy_bad, 0);
        check({tag, "_idle_quiet"}, stray, 0);
        check({tag, "_word_count"}, 32'(word_count), 32'(n));
        check({tag, "_err_count"}, 32'(err_count), exp_err);
        check({tag, "_first_valid"}, 32'(first_err_valid), (exp_err > 0) ? 1 : 0);
        if (exp_err > 0) check({tag, "_first_idx"}, 32'(first_err_idx), exp_first);
        exp_word_q.delete();
        exp_mask_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    int done_seen;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        flip_pos  = 5'd0;
        num_words = 16'd0;
        seed      = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_data_in", 32'(codec_data_in), 0);
        check("reset_flip", 32'(codec_bit_flip), 0);
        check("reset_stats", 32'({word_count, err_count} | 32'(first_err_idx)), 0);
        check("reset_first_valid", 32'(first_err_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        run_burst("m0_default_seed", 2'd0, 5'd0, 16'd8, 16'd0, 1'b0);
        run_burst("m2_walk_wrap", 2'd2, 5'd18, 16'd25, 16'hBEEF, 1'b0);
        run_burst("m3_double_p0", 2'd3, 5'd0, 16'd10, 16'h5A5A, 1'b0);
        run_burst("m1_pos31_drain_poke", 2'd1, 5'd31, 16'd4, 16'h0F0F, 1'b1);
        run_burst("m1_parity15", 2'd1, 5'd15, 16'd6, 16'h1357, 1'b0);
        run_burst("m3_double_p20", 2'd3, 5'd20, 16'd6, 16'h2468, 1'b0);

        // Reset in the middle of a long burst.
        mode      = 2'd1;
        flip_pos  = 5'd3;
        num_words = 16'd100;
        seed      = 16'h1234;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_data_in", 32'(codec_data_in), 0);
        check("abort_flip", 32'(codec_bit_flip), 0);
        check("abort_word_count", 32'(word_count), 0);
        check("abort_err_first", 32'({err_count, first_err_idx}) | 32'(first_err_valid), 0);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", done_seen, 0);

        // Zero-length burst: one DONE cycle and no codec traffic.
        num_words = 16'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_busy", 32'(busy), 1);
        check("zero_done", 32'(done), 1);
        check("zero_data_in", 32'(codec_data_in), 0);
        @(negedge clk);
        check("zero_busy_after", 32'(busy), 0);
        check("zero_done_after", 32'(done), 0);
        check("zero_flip_after", 32'(codec_bit_flip), 0);
        check("zero_word_count", 32'(word_count), 0);

        run_burst("after_abort", 2'd0, 5'd0, 16'd3, 16'h00C3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
